// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants, PC source encoding and branch opcodes
// Contents:
//   PC_W, INSTR_W    default PC and instruction widths
//   pc_sel_e         PC source select encoding driven by the hazard controller
//   OP_*             7-bit branch opcodes, opcode = {instr[17:13], instr[1:0]}
//   is_cond_branch   true for BREQ/BRNE/BRCS/BRCC
//   is_branch        true for any conditional branch or BRN
package pipeline_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 18;

  typedef enum logic [2:0] {
    PC_DEC   = 3'd0,
    PC_STACK = 3'd1,
    PC_INT   = 3'd2,
    PC_CORR  = 3'd3,
    PC_PRED  = 3'd4
  } pc_sel_e;

  localparam logic [6:0] OP_BRN  = 7'b0010000;
  localparam logic [6:0] OP_BREQ = 7'b0010010;
  localparam logic [6:0] OP_BRNE = 7'b0010011;
  localparam logic [6:0] OP_BRCS = 7'b0010100;
  localparam logic [6:0] OP_BRCC = 7'b0010101;

  function automatic logic is_cond_branch(input logic [6:0] opcode);
    return (opcode == OP_BREQ) || (opcode == OP_BRNE) ||
           (opcode == OP_BRCS) || (opcode == OP_BRCC);
  endfunction

  function automatic logic is_branch(input logic [6:0] opcode);
    return (opcode == OP_BRN) || is_cond_branch(opcode);
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// rtl/fetch_predecode.sv - static backward-taken/forward-not-taken branch predictor
// Combinational predecode of the fetch latch contents.
// Ports:
//   instr   in   INSTR_W  latched instruction
//   pc      in   PC_W     PC of instr
//   valid   in   1        instr is a real instruction
//   taken   out  1        predicted taken
//   target  out  PC_W     branch target field instr[12:3]
module fetch_predecode #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 18
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    pc,
  input  logic               valid,
  output logic               taken,
  output logic [PC_W-1:0]    target
);
  import pipeline_pkg::*;

  logic [6:0] opcode;

  always_comb begin
    opcode = {instr[17:13], instr[1:0]};
    target = instr[12:3];
    // Loops branch backwards, so a target at or below the branch is predicted
    // taken; BRN is always taken.
    taken  = valid && ((opcode == OP_BRN) ||
                       (is_cond_branch(opcode) && (target <= pc)));
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, PC source mux, imem address mux, fetch latch
// Optional feature macro: STATIC_BRANCH_PREDICT_EN (static predecode of the fetch latch).
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   pc_reset                   controller PC reset (same as reset for the PC)
//   pc_inc, pc_load            advance PC / load PC from pc_mux_sel source (load wins)
//   pc_mux_sel                 0 dec, 1 stack, 2 INT_VECTOR, 3 correction, 4 predicted, 5-7 hold
//   imem_addr_mux              1 replays if_pc, 0 fetches pc_q
//   fetch_latch_stall          hold the fetch latch
//   fetch_flush                invalidate the fetch latch (overrides stall)
//   dec_target, stack_target, correction_target   PC load sources
//   imem_addr, imem_data       instruction memory address out / read data in
//   if_instr, if_pc, if_valid  fetch latch to decode
//   predicted_branch_taken, predicted_target      static prediction for if_instr
module fetch_stage #(
  parameter int              PC_W       = pipeline_pkg::PC_W,
  parameter int              INSTR_W    = pipeline_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC   = 10'h000,
  parameter logic [PC_W-1:0] INT_VECTOR = 10'h3FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_reset,
  input  logic               pc_inc,
  input  logic               pc_load,
  input  logic [2:0]         pc_mux_sel,
  input  logic               imem_addr_mux,
  input  logic               fetch_latch_stall,
  input  logic               fetch_flush,
  input  logic [PC_W-1:0]    dec_target,
  input  logic [PC_W-1:0]    stack_target,
  input  logic [PC_W-1:0]    correction_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid,
  output logic               predicted_branch_taken,
  output logic [PC_W-1:0]    predicted_target
);
  import pipeline_pkg::*;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_src;

  always_comb begin
    pc_src = pc_q;
    case (pc_mux_sel)
      PC_DEC:   pc_src = dec_target;
      PC_STACK: pc_src = stack_target;
      PC_INT:   pc_src = INT_VECTOR;
      PC_CORR:  pc_src = correction_target;
      PC_PRED:  pc_src = predicted_target;
      default:  pc_src = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || pc_reset) begin
      pc_q <= RESET_PC;
    end else if (pc_load) begin
      pc_q <= pc_src;
    end else if (pc_inc) begin
      pc_q <= pc_q + PC_W'(1);
    end
  end

  // Replay mode re-reads the instruction already in the latch so a stalled
  // decode sees consistent memory data.
  assign imem_addr = imem_addr_mux ? if_pc : pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      if_instr <= '0;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else if (fetch_flush) begin
      // Keep the current PC so a flushed slot still carries a sensible address.
      if_instr <= '0;
      if_pc    <= pc_q;
      if_valid <= 1'b0;
    end else if (!fetch_latch_stall) begin
      if_instr <= imem_data;
      if_pc    <= imem_addr;
      if_valid <= 1'b1;
    end
  end

`ifdef STATIC_BRANCH_PREDICT_EN
  fetch_predecode #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_predecode (
    .instr  (if_instr),
    .pc     (if_pc),
    .valid  (if_valid),
    .taken  (predicted_branch_taken),
    .target (predicted_target)
  );
`else
  assign predicted_branch_taken = 1'b0;
  assign predicted_target       = '0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage. It is driven by the hazard/pipeline controller.
- Owns the program counter, the PC source mux and the instruction-memory address mux.
- Owns the fetch latch, which registers instruction, PC and valid into decode.
- Optionally predecodes the latched instruction and returns a static branch prediction (taken flag + target) to the controller.

Parameters:
- PC_W, 10, width of PC and all target addresses
- INSTR_W, 18, instruction width
- RESET_PC, 10'h000, PC value after reset or pc_reset
- INT_VECTOR, 10'h3FF, PC loaded for pc_mux_sel=2

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clock clk
- pc_reset  in  1  controller PC reset, same effect on PC as reset
- pc_inc  in  1  advance PC by 1
- pc_load  in  1  load PC from source selected by pc_mux_sel
- pc_mux_sel  in  3  0=dec_target, 1=stack_target, 2=INT_VECTOR, 3=correction_target, 4=predicted_target, 5-7=hold pc_q
- imem_addr_mux  in  1  1: replay address if_pc; 0: fetch address pc_q
- fetch_latch_stall  in  1  hold fetch latch contents
- fetch_flush  in  1  invalidate fetch latch (branch miss / redirect)
- dec_target  in  PC_W  call/jump target from decode
- stack_target  in  PC_W  return address from stack
- correction_target  in  PC_W  mispredict correction address from execute
- imem_addr  out  PC_W  instruction memory address (combinational)
- imem_data  in  INSTR_W  instruction memory read data, combinational ROM, valid same cycle
- if_instr  out  INSTR_W  latched instruction to decode
- if_pc  out  PC_W  PC of if_instr
- if_valid  out  1  if_instr is a real instruction
- predicted_branch_taken  out  1  static prediction for if_instr
- predicted_target  out  PC_W  predicted branch target

Behaviour:
- Reset state: pc_q=RESET_PC, if_instr=0, if_pc=0, if_valid=0. imem_addr=RESET_PC (mux=0). predicted_branch_taken=0, predicted_target=0.
- PC update priority per edge: reset | pc_reset -> RESET_PC; else pc_load -> mux source (sel 5-7 hold); else pc_inc -> pc_q+1 mod 2^PC_W (3FF wraps to 000); else hold.
- pc_load and pc_inc both high: pc_load wins.
- imem_addr = imem_addr_mux ? if_pc : pc_q.
- Fetch latch update priority: reset -> cleared; else fetch_flush -> if_valid=0, if_instr=0, if_pc=pc_q; else fetch_latch_stall -> hold all; else capture {imem_data, imem_addr, 1}.
- fetch_flush overrides fetch_latch_stall in the same cycle.
- Latency: an instruction at address A presented on cycle N appears on if_instr/if_pc at N+1.
- Redirect: pc_load at edge N makes target fetch at N+1 and visible to decode at N+2. The wrong-path instruction latched at N is killed by fetch_flush or by the controller's decode NOP.
- Stall with replay: with imem_addr_mux=1 and latch stalled, the latch keeps if_pc. No instruction is lost; PC holds unless pc_load/pc_inc.
- Reset mid-stall or mid-redirect: reset wins unconditionally; next cycle fetches RESET_PC.

Optional Feature:
- Macro STATIC_BRANCH_PREDICT_EN.
- Defined: combinational predecode of if_instr, using opcode = {if_instr[17:13], if_instr[1:0]}.
- Conditional branches: BREQ 0010010, BRNE 0010011, BRCS 0010100, BRCC 0010101. Unconditional: BRN 0010000.
- predicted_target = if_instr[12:3].
- predicted_branch_taken = if_valid && (BRN || (conditional && predicted_target <= if_pc)), i.e. backward-taken, forward-not-taken.
- Not defined: predicted_branch_taken=0, predicted_target=0; the controller's mux source 4 is never requested.

Decomposition:
- Package pipeline_pkg holds:
  - PC_W/INSTR_W constants
  - PcSel enum (PC_DEC=0, PC_STACK=1, PC_INT=2, PC_CORR=3, PC_PRED=4)
  - branch opcode localparams
  - is_branch function
- One sub-module: fetch_predecode (combinational opcode decode + prediction, instantiated only under STATIC_BRANCH_PREDICT_EN).

Test Plan:
- Reset, then pc_inc held 4 cycles, ROM[n]=n+100 -> if_pc 0,1,2,3; if_instr 100..103; if_valid 0 in first cycle after reset.
- pc_q=3FF, pc_inc -> pc_q=000, imem_addr=000.
- pc_load=1, pc_inc=1, sel=2 at pc=05 -> pc_q=3FF; sel=3, correction_target=0x40 -> pc_q=0x40; sel=6 -> pc_q unchanged.
- Stall: fetch_latch_stall=1, imem_addr_mux=1 for 2 cycles with if_pc=0x12 -> imem_addr=0x12, latch holds; release -> next instruction 0x13 latched.
- fetch_flush and fetch_latch_stall high together -> if_valid=0 next cycle.
- Predict enabled: if_pc=0x20, BRNE target 0x10 -> taken=1, target=0x10; target 0x30 -> taken=0; BRN to 0x30 -> taken=1; macro off -> taken=0 always.
